// File: rtl/dsp_capture_sequencer.sv
// Triggered snapshot controller: arms, waits for a trigger on the decimated stream, stores a window into a buffer.
// Optional feature macro: PRETRIG_EN (circular pre-trigger history in ARMED; adds the pretrig port).
module dsp_capture_sequencer #(
    parameter int DW = 16,
    parameter int AW = 10
) (
    input  logic          sys_clk,
    input  logic          reset,
    input  logic          arm,
    input  logic          abort,
    input  logic [1:0]    trig_mode,
    input  logic [DW-1:0] trig_level,
    input  logic [AW:0]   cap_len,
`ifdef PRETRIG_EN
    input  logic [AW-1:0] pretrig,
`endif
    input  logic          s_valid,
    input  logic [DW-1:0] s_data,
    output logic          armed,
    output logic          busy,
    output logic          triggered,
    output logic          done,
    output logic [AW:0]   wr_count,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_data
);
    typedef enum logic [1:0] {ST_IDLE, ST_ARMED, ST_CAPTURE, ST_DONE} state_t;
    localparam logic [AW:0] DEPTH = {1'b1, {AW{1'b0}}};

    state_t               r_state, w_state_next;
    logic [1:0]           r_mode;
    logic signed [DW-1:0] r_level, r_prev, w_cur;
    logic                 r_prev_valid, r_triggered;
    logic [AW:0]          r_len, r_wr_count;
    logic [AW-1:0]        r_wr_addr;
    logic [DW-1:0]        r_rd_data;
    logic [DW-1:0]        r_mem [0:(1<<AW)-1];

    logic        w_run, w_arm_ok, w_sample, w_active, w_cond, w_qual;
    logic        w_trig, w_cap_wr, w_wr_en;
    logic [AW:0] w_len_in, w_cnt_inc, w_trig_count;
    logic [AW-1:0] w_rd_phys;

    assign w_cur    = $signed(s_data);
    assign w_len_in = (cap_len == '0 || cap_len > DEPTH) ? DEPTH : cap_len;
    assign w_run    = !abort;
    assign w_arm_ok = arm && w_run && (r_state == ST_IDLE || r_state == ST_DONE);
    assign w_active = (r_state == ST_ARMED) || (r_state == ST_CAPTURE);
    assign w_sample = w_run && s_valid && w_active;
    assign w_trig   = w_sample && (r_state == ST_ARMED) && w_cond && w_qual;
    assign w_cap_wr = w_sample && (r_state == ST_CAPTURE);
    assign w_cnt_inc = r_wr_count + 1'b1;

`ifdef PRETRIG_EN
    logic [AW-1:0] r_pre_eff, r_pre_cnt, r_base;
    logic [AW-1:0] w_len_m1, w_pre_eff_in;

    // Pre-trigger depth is capped so at least the trigger sample fits in the window.
    assign w_len_m1     = w_len_in[AW-1:0] - 1'b1;
    assign w_pre_eff_in = ({1'b0, pretrig} < w_len_in) ? pretrig : w_len_m1;
    assign w_qual       = (r_pre_cnt >= r_pre_eff);
    assign w_trig_count = {1'b0, r_pre_eff} + 1'b1;
    assign w_rd_phys    = rd_addr + r_base;
    assign w_wr_en      = w_sample;
`else
    assign w_qual       = 1'b1;
    assign w_trig_count = {{AW{1'b0}}, 1'b1};
    assign w_rd_phys    = rd_addr;
    assign w_wr_en      = w_trig || w_cap_wr;
`endif

    always_comb begin
        w_cond = 1'b1;
        case (r_mode)
            2'b01:   w_cond = r_prev_valid && (r_prev < r_level) && (w_cur >= r_level);
            2'b10:   w_cond = r_prev_valid && (r_prev > r_level) && (w_cur <= r_level);
            default: w_cond = 1'b1;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        armed        = (r_state == ST_ARMED);
        busy         = w_active;
        done         = (r_state == ST_DONE);
        if (abort) begin
            w_state_next = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: if (arm) w_state_next = ST_ARMED;
                ST_ARMED:   if (w_trig) w_state_next = (w_trig_count == r_len) ? ST_DONE : ST_CAPTURE;
                ST_CAPTURE: if (w_cap_wr && w_cnt_inc == r_len) w_state_next = ST_DONE;
                default:    w_state_next = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge sys_clk) begin
        if (reset) begin
            r_mode       <= '0;
            r_level      <= '0;
            r_len        <= '0;
            r_prev       <= '0;
            r_prev_valid <= 1'b0;
            r_wr_count   <= '0;
            r_wr_addr    <= '0;
            r_triggered  <= 1'b0;
`ifdef PRETRIG_EN
            r_pre_eff    <= '0;
            r_pre_cnt    <= '0;
            r_base       <= '0;
`endif
        end else begin
            r_triggered <= w_trig;
            if (w_arm_ok) begin
                r_mode       <= trig_mode;
                r_level      <= $signed(trig_level);
                r_len        <= w_len_in;
                r_prev_valid <= 1'b0;
                r_wr_count   <= '0;
                r_wr_addr    <= '0;
`ifdef PRETRIG_EN
                r_pre_eff    <= w_pre_eff_in;
                r_pre_cnt    <= '0;
`endif
            end else if (w_sample) begin
                r_prev       <= w_cur;
                r_prev_valid <= 1'b1;
                if (w_wr_en)       r_wr_addr  <= r_wr_addr + 1'b1;
                if (w_trig)        r_wr_count <= w_trig_count;
                else if (w_cap_wr) r_wr_count <= w_cnt_inc;
`ifdef PRETRIG_EN
                if (r_state == ST_ARMED && r_pre_cnt != '1) r_pre_cnt <= r_pre_cnt + 1'b1;
                if (w_trig) r_base <= r_wr_addr - r_pre_eff;
`endif
            end
        end
    end

    // Buffer contents deliberately survive reset; only the read register clears.
    always_ff @(posedge sys_clk) begin
        if (!reset && w_wr_en) r_mem[r_wr_addr] <= s_data;
    end

    always_ff @(posedge sys_clk) begin
        if (reset) r_rd_data <= '0;
        else       r_rd_data <= r_mem[w_rd_phys];
    end

    assign triggered = r_triggered;
    assign wr_count  = r_wr_count;
    assign rd_data   = r_rd_data;
endmodule

// File: tb/tb_dsp_capture_sequencer.sv
// Self-checking bench for dsp_capture_sequencer: capture-vector table plus hand-written abort/reset/long-capture sequences.
module tb_dsp_capture_sequencer;
    localparam int DW = 16;
    localparam int AW = 10;

    logic          clk = 1'b0;
    logic          reset, arm, abort, s_valid;
    logic [1:0]    trig_mode;
    logic [DW-1:0] trig_level, s_data;
    logic [AW:0]   cap_len;
    logic [AW-1:0] rd_addr;
    logic          armed, busy, triggered, done;
    logic [AW:0]   wr_count;
    logic [DW-1:0] rd_data;
`ifdef PRETRIG_EN
    logic [AW-1:0] pretrig;
`endif

    dsp_capture_sequencer #(.DW(DW), .AW(AW)) dut (
        .sys_clk(clk), .reset(reset), .arm(arm), .abort(abort),
        .trig_mode(trig_mode), .trig_level(trig_level), .cap_len(cap_len),
`ifdef PRETRIG_EN
        .pretrig(pretrig),
`endif
        .s_valid(s_valid), .s_data(s_data),
        .armed(armed), .busy(busy), .triggered(triggered), .done(done),
        .wr_count(wr_count), .rd_addr(rd_addr), .rd_data(rd_data)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0]        mode;
        logic [15:0]       level;
        logic [10:0]       len;
        logic [3:0]        n;
        logic [3:0]        trig;
        logic [5:0][15:0]  smp;
    } vec_t;

    vec_t vecs[$];
    int   exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic add_vec(input logic [1:0] m, input int lvl, input int ln, input int n, input int tr,
                           input int s0, input int s1, input int s2, input int s3, input int s4, input int s5);
        vec_t v;
        v.mode = m; v.level = 16'(lvl); v.len = 11'(ln); v.n = 4'(n); v.trig = 4'(tr);
        v.smp[0] = 16'(s0); v.smp[1] = 16'(s1); v.smp[2] = 16'(s2);
        v.smp[3] = 16'(s3); v.smp[4] = 16'(s4); v.smp[5] = 16'(s5);
        vecs.push_back(v);
    endtask

    // Arm with the given config, then scramble the config inputs so latching is exercised.
    task automatic arm_cfg(input logic [1:0] m, input int lvl, input int ln, input string tag);
        trig_mode = m; trig_level = 16'(lvl); cap_len = 11'(ln);
        arm = 1'b1;
        tick();
        arm = 1'b0;
        trig_mode = 2'b11; trig_level = 16'($urandom); cap_len = 11'd1;
        chk({tag, " armed"}, int'(armed), 1);
        chk({tag, " busy"}, int'(busy), 1);
        chk({tag, " wr0"}, int'(wr_count), 0);
    endtask

    task automatic read_back(input int addr, input string tag);
        int e;
        rd_addr = AW'(addr);
        tick();
        if (exp_q.size() == 0) begin
            chk({tag, " queue_underflow"}, 1, 0);
        end else begin
            e = exp_q.pop_front();
            chk($sformatf("%s rd%0d", tag, addr), int'($signed(rd_data)), e);
            $display("%s read addr %0d -> %0d", tag, addr, int'($signed(rd_data)));
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int wexp, rdlist[4];
        reset = 1'b1; arm = 1'b0; abort = 1'b0; s_valid = 1'b0; s_data = '0;
        trig_mode = '0; trig_level = '0; cap_len = '0; rd_addr = '0;
`ifdef PRETRIG_EN
        pretrig = '0;
`endif
        add_vec(2'b00,   0, 4, 5, 0,  10,  11,  12,  13, 14, 0);
        add_vec(2'b01, 100, 2, 4, 2,  50,  99, 100, 150,  0, 0);
        add_vec(2'b01, 100, 1, 3, 2, 200,  50, 120,   0,  0, 0);
        add_vec(2'b10,   0, 3, 4, 1,   5,   0,  -3,  -7,  0, 0);
        add_vec(2'b11,  77, 1, 2, 0,  -1,   2,   0,   0,  0, 0);
        add_vec(2'b10, -10, 2, 3, 1,  -5, -20, -30,   0,  0, 0);
        add_vec(2'b01,  10, 1, 4, 3,  10,  20,   5,  10,  0, 0);

        repeat (3) tick();
        chk("reset armed", int'(armed), 0);
        chk("reset busy", int'(busy), 0);
        chk("reset triggered", int'(triggered), 0);
        chk("reset done", int'(done), 0);
        chk("reset wr_count", int'(wr_count), 0);
        chk("reset rd_data", int'(rd_data), 0);
        reset = 1'b0;
        tick();

        foreach (vecs[v]) begin
            string tag;
            tag = $sformatf("v%0d", v);
            arm_cfg(vecs[v].mode, int'($signed(vecs[v].level)), int'(vecs[v].len), tag);
            for (int i = 0; i < int'(vecs[v].n); i++) begin
                int t, l;
                t = int'(vecs[v].trig);
                l = int'(vecs[v].len);
                if (i >= t && i < t + l) exp_q.push_back(int'($signed(vecs[v].smp[i])));
                s_valid = 1'b1; s_data = vecs[v].smp[i];
                tick();
                wexp = (i < t) ? 0 : ((i - t + 1 < l) ? i - t + 1 : l);
                chk($sformatf("%s trig s%0d", tag, i), int'(triggered), (i == t) ? 1 : 0);
                chk($sformatf("%s wr s%0d", tag, i), int'(wr_count), wexp);
                chk($sformatf("%s done s%0d", tag, i), int'(done), (i >= t + l - 1) ? 1 : 0);
                s_valid = 1'b0; s_data = 16'($urandom);
                tick();
                chk($sformatf("%s gap trig s%0d", tag, i), int'(triggered), 0);
                chk($sformatf("%s gap wr s%0d", tag, i), int'(wr_count), wexp);
            end
            chk({tag, " end busy"}, int'(busy), 0);
            for (int a = 0; a < int'(vecs[v].len); a++) read_back(a, tag);
            $display("%s mode %0d len %0d captured %0d samples", tag, vecs[v].mode, vecs[v].len, wr_count);
        end
        chk("table queue drained", exp_q.size(), 0);

        // Abort mid-capture, then arm+abort together.
        arm_cfg(2'b00, 0, 4, "abort");
        for (int i = 1; i <= 2; i++) begin
            s_valid = 1'b1; s_data = 16'(i);
            tick();
        end
        s_valid = 1'b0;
        chk("abort pre wr", int'(wr_count), 2);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort busy", int'(busy), 0);
        chk("abort armed", int'(armed), 0);
        chk("abort done", int'(done), 0);
        chk("abort wr frozen", int'(wr_count), 2);
        arm = 1'b1; abort = 1'b1; cap_len = 11'd4; trig_mode = 2'b00;
        tick();
        arm = 1'b0; abort = 1'b0;
        chk("arm+abort armed", int'(armed), 0);
        chk("arm+abort busy", int'(busy), 0);
        s_valid = 1'b1; s_data = 16'd9;
        tick();
        s_valid = 1'b0;
        chk("idle no trig", int'(triggered), 0);
        chk("idle wr", int'(wr_count), 2);
        $display("abort sequence done, wr_count %0d", wr_count);

        // Full-depth capture via cap_len=0, sparse valid, arm ignored while capturing.
        rdlist = '{0, 1, 511, 1023};
        arm_cfg(2'b00, 0, 0, "full");
        for (int k = 0; k < 1024; k++) begin
            if (k == 0 || k == 1 || k == 511 || k == 1023) exp_q.push_back(k);
            s_valid = 1'b1; s_data = 16'(k);
            tick();
            s_valid = 1'b0;
            if (k == 0) chk("full trig", int'(triggered), 1);
            if (k == 1022) begin
                chk("full done early", int'(done), 0);
                chk("full wr 1023", int'(wr_count), 1023);
            end
            if (k == 5) begin
                arm = 1'b1; cap_len = 11'd1; trig_mode = 2'b01;
            end
            tick();
            arm = 1'b0;
            if (k == 5) begin
                chk("arm in capture busy", int'(busy), 1);
                chk("arm in capture wr", int'(wr_count), 6);
            end
            tick();
        end
        chk("full done", int'(done), 1);
        chk("full busy", int'(busy), 0);
        chk("full wr 1024", int'(wr_count), 1024);
        s_valid = 1'b1; s_data = 16'd5000;
        tick();
        s_valid = 1'b0;
        chk("full post wr", int'(wr_count), 1024);
        foreach (rdlist[j]) read_back(rdlist[j], "full");
        chk("full queue drained", exp_q.size(), 0);

        // Reset in the middle of a capture.
        arm_cfg(2'b00, 0, 4, "rst");
        s_valid = 1'b1; s_data = 16'd7;
        tick();
        s_valid = 1'b0;
        chk("rst trig", int'(triggered), 1);
        reset = 1'b1;
        tick();
        chk("rst busy", int'(busy), 0);
        chk("rst wr", int'(wr_count), 0);
        chk("rst triggered", int'(triggered), 0);
        chk("rst rd_data", int'(rd_data), 0);
        reset = 1'b0;
        tick();
        $display("reset-mid-capture sequence done");

`ifdef PRETRIG_EN
        pretrig = 10'd2;
        arm_cfg(2'b01, 10, 5, "pre");
        pretrig = 10'd7;
        for (int k = 0; k < 15; k++) begin
            if (k >= 8 && k <= 12) exp_q.push_back(k);
            s_valid = 1'b1; s_data = 16'(k);
            tick();
            chk($sformatf("pre trig s%0d", k), int'(triggered), (k == 10) ? 1 : 0);
            if (k == 10) chk("pre wr at trig", int'(wr_count), 3);
            if (k == 11) chk("pre done early", int'(done), 0);
            if (k == 12) chk("pre done", int'(done), 1);
        end
        s_valid = 1'b0;
        chk("pre wr final", int'(wr_count), 5);
        for (int a = 0; a < 5; a++) read_back(a, "pre");
        chk("pre queue drained", exp_q.size(), 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
